// File: rtl/box_table_loader.sv
// Double-buffered box descriptor table: writes land in a shadow copy, which is committed
// atomically to the active copy at a frame boundary. Optional macro: BOXTBL_TIMEOUT_EN.
module box_table_loader #(
   parameter int unsigned NBOX    = 10,
   parameter int unsigned CW      = 12,
   parameter int unsigned TW      = 8,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 frame_start_i,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [3:0]           wr_idx_i,
   input  logic [CW-1:0]        wr_xmin_i,
   input  logic [CW-1:0]        wr_xmax_i,
   input  logic [CW-1:0]        wr_ymin_i,
   input  logic [CW-1:0]        wr_ymax_i,
   input  logic [TW-1:0]        wr_BDthY_i,
   input  logic [TW-1:0]        wr_BDthU_i,
   input  logic [TW-1:0]        wr_BDthV_i,
   input  logic [TW-1:0]        wr_Bth_i,
   input  logic [TW-1:0]        wr_BckGndBuildTH_i,
   input  logic                 wr_update_i,
   input  logic                 commit_req_i,
   output logic                 commit_pending_o,
   output logic                 commit_done_o,
   output logic                 err_idx_o,
   output logic                 timeout_o,
   output logic [NBOX*CW-1:0]   box_xmin_o,
   output logic [NBOX*CW-1:0]   box_xmax_o,
   output logic [NBOX*CW-1:0]   box_ymin_o,
   output logic [NBOX*CW-1:0]   box_ymax_o,
   output logic [NBOX*TW-1:0]   BDthY_o,
   output logic [NBOX*TW-1:0]   BDthU_o,
   output logic [NBOX*TW-1:0]   BDthV_o,
   output logic [NBOX*TW-1:0]   Bth_o,
   output logic [NBOX*TW-1:0]   BckGndBuildTH_o,
   output logic [NBOX-1:0]      update_o
);

   if (NBOX < 1 || NBOX > 16 || TIMEOUT < 1 || TIMEOUT > 32'd1048575) begin : g_bad_param
      $error("box_table_loader: NBOX or TIMEOUT out of range");
   end

   typedef struct packed {
      logic [CW-1:0] xmin;
      logic [CW-1:0] xmax;
      logic [CW-1:0] ymin;
      logic [CW-1:0] ymax;
      logic [TW-1:0] thy;
      logic [TW-1:0] thu;
      logic [TW-1:0] thv;
      logic [TW-1:0] bth;
      logic [TW-1:0] bck;
      logic          upd;
   } entry_t;

   typedef enum logic [0:0] {StIdle, StArmed} state_e;

   state_e state_q, state_d;
   entry_t shadow_q [NBOX];
   entry_t active_q [NBOX];
   entry_t wr_entry;
   logic   wr_hs, idx_ok, commit, commit_done_q, err_idx_q, tmo_hit;

   assign idx_ok = ({1'b0, wr_idx_i} < 5'(NBOX));
   assign wr_hs  = wr_valid_i && wr_ready_o;

   always_comb begin
      wr_entry = '{xmin: wr_xmin_i, xmax: wr_xmax_i, ymin: wr_ymin_i, ymax: wr_ymax_i,
                   thy: wr_BDthY_i, thu: wr_BDthU_i, thv: wr_BDthV_i, bth: wr_Bth_i,
                   bck: wr_BckGndBuildTH_i, upd: wr_update_i};
   end

   // A frame_start coinciding with commit_req in IDLE only arms; the commit waits a frame.
   always_comb begin
      state_d    = state_q;
      wr_ready_o = 1'b0;
      commit     = 1'b0;
      case (state_q)
         StIdle: begin
            wr_ready_o = 1'b1;
            if (commit_req_i) state_d = StArmed;
         end
         StArmed: begin
            if (frame_start_i || tmo_hit) begin
               commit  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         commit_done_q <= 1'b0;
         err_idx_q     <= 1'b0;
         for (int unsigned i = 0; i < NBOX; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         commit_done_q <= commit;
         if (wr_hs && !idx_ok) err_idx_q <= 1'b1;
         for (int unsigned i = 0; i < NBOX; i++) begin
            if (wr_hs && wr_idx_i == 4'(i)) shadow_q[i] <= wr_entry;
            if (commit) active_q[i] <= shadow_q[i];
         end
      end
   end

`ifdef BOXTBL_TIMEOUT_EN
   logic [19:0] tmo_cnt_q;
   logic        timeout_q;

   assign tmo_hit = (state_q == StArmed) && (tmo_cnt_q == 20'(TIMEOUT - 1));

   // Counter idles at zero so it starts from zero on every entry to ARMED.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == StArmed) tmo_cnt_q <= tmo_cnt_q + 20'd1;
         else                    tmo_cnt_q <= '0;
         if (tmo_hit && !frame_start_i) timeout_q <= 1'b1;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   assign commit_pending_o = (state_q == StArmed);
   assign commit_done_o    = commit_done_q;
   assign err_idx_o        = err_idx_q;

   for (genvar g = 0; g < NBOX; g++) begin : g_out
      assign box_xmin_o[g*CW +: CW]      = active_q[g].xmin;
      assign box_xmax_o[g*CW +: CW]      = active_q[g].xmax;
      assign box_ymin_o[g*CW +: CW]      = active_q[g].ymin;
      assign box_ymax_o[g*CW +: CW]      = active_q[g].ymax;
      assign BDthY_o[g*TW +: TW]         = active_q[g].thy;
      assign BDthU_o[g*TW +: TW]         = active_q[g].thu;
      assign BDthV_o[g*TW +: TW]         = active_q[g].thv;
      assign Bth_o[g*TW +: TW]           = active_q[g].bth;
      assign BckGndBuildTH_o[g*TW +: TW] = active_q[g].bck;
      assign update_o[g]                 = active_q[g].upd;
   end

endmodule

// File: tb/tb_box_table_loader.sv
// Directed bench for box_table_loader: reset, commit timing, write blocking, bad index,
// arm/frame coincidence, overwrite and the optional timeout path.
module tb_box_table_loader;
   localparam int NBOX = 10;
   localparam int CW   = 12;
   localparam int TW   = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic frame_start = 1'b0, wr_valid = 1'b0, commit_req = 1'b0, wr_update = 1'b0;
   logic [3:0] wr_idx = '0;
   logic [CW-1:0] wr_xmin = '0, wr_xmax = '0, wr_ymin = '0, wr_ymax = '0;
   logic [TW-1:0] wr_thy = '0, wr_thu = '0, wr_thv = '0, wr_bth = '0, wr_bck = '0;
   logic wr_ready, commit_pending, commit_done, err_idx, timeout;
   logic [NBOX*CW-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
   logic [NBOX*TW-1:0] thy, thu, thv, bth, bck;
   logic [NBOX-1:0] update;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   box_table_loader #(.NBOX(NBOX), .CW(CW), .TW(TW), .TIMEOUT(100)) dut (
      .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_idx_i(wr_idx),
      .wr_xmin_i(wr_xmin), .wr_xmax_i(wr_xmax), .wr_ymin_i(wr_ymin), .wr_ymax_i(wr_ymax),
      .wr_BDthY_i(wr_thy), .wr_BDthU_i(wr_thu), .wr_BDthV_i(wr_thv), .wr_Bth_i(wr_bth),
      .wr_BckGndBuildTH_i(wr_bck), .wr_update_i(wr_update),
      .commit_req_i(commit_req), .commit_pending_o(commit_pending),
      .commit_done_o(commit_done), .err_idx_o(err_idx), .timeout_o(timeout),
      .box_xmin_o(box_xmin), .box_xmax_o(box_xmax), .box_ymin_o(box_ymin),
      .box_ymax_o(box_ymax), .BDthY_o(thy), .BDthU_o(thu), .BDthV_o(thv), .Bth_o(bth),
      .BckGndBuildTH_o(bck), .update_o(update)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic [3:0] idx, input logic [CW-1:0] x0, input logic [CW-1:0] x1,
                         input logic [CW-1:0] y0, input logic [CW-1:0] y1,
                         input logic [TW-1:0] t, input logic upd);
      wr_idx = idx; wr_xmin = x0; wr_xmax = x1; wr_ymin = y0; wr_ymax = y1;
      wr_thy = t; wr_thu = t + 8'd1; wr_thv = t + 8'd2; wr_bth = t + 8'd3; wr_bck = t + 8'd4;
      wr_update = upd;
   endtask

   task automatic do_write(input logic [3:0] idx, input logic [CW-1:0] x0,
                           input logic [CW-1:0] x1, input logic [CW-1:0] y0,
                           input logic [CW-1:0] y1, input logic [TW-1:0] t, input logic upd);
      set_wr(idx, x0, x1, y0, y1, t, upd);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if ({box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
         errors++; $display("FAIL reset_bounds got %0h want 0", {box_xmin, box_xmax});
      end
      checks++;
      if ({thy, thu, thv, bth, bck, update} !== '0) begin
         errors++; $display("FAIL reset_thresholds got %0h want 0", {thy, update});
      end
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready);
      end
      checks++;
      if ({commit_pending, commit_done, err_idx, timeout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {commit_pending, commit_done, err_idx, timeout});
      end
   endtask

   task automatic test_commit();
      int early = 0;
      int pulses;
      do_write(4'd2, 12'd10, 12'd50, 12'd20, 12'd60, 8'h33, 1'b1);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      checks++;
      if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
         errors++; $display("FAIL armed_flags got pend=%b rdy=%b want pend=1 rdy=0", commit_pending, wr_ready);
      end
      repeat (7) begin
         tick();
         if (box_xmin !== '0 || thy !== '0 || update !== '0 || commit_done !== 1'b0) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++; $display("FAIL early_change got %0d changed cycles want 0", early);
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if ({box_xmin[24 +: 12], box_xmax[24 +: 12], box_ymin[24 +: 12], box_ymax[24 +: 12]}
          !== {12'd10, 12'd50, 12'd20, 12'd60}) begin
         errors++;
         $display("FAIL commit_bounds got %0h want 00a03201403c",
                  {box_xmin[24 +: 12], box_xmax[24 +: 12], box_ymin[24 +: 12], box_ymax[24 +: 12]});
      end
      checks++;
      if ({thy[16 +: 8], thu[16 +: 8], bck[16 +: 8]} !== 24'h333437) begin
         errors++; $display("FAIL commit_thr got %0h want 333437", {thy[16 +: 8], thu[16 +: 8], bck[16 +: 8]});
      end
      checks++;
      if (update !== 10'h004) begin
         errors++; $display("FAIL commit_update got %0h want 004", update);
      end
      checks++;
      if (commit_done !== 1'b1 || commit_pending !== 1'b0) begin
         errors++; $display("FAIL commit_done got done=%b pend=%b want done=1 pend=0", commit_done, commit_pending);
      end
      pulses = 1;
      repeat (5) begin
         tick();
         if (commit_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 1) begin
         errors++; $display("FAIL done_pulses got %0d want 1", pulses);
      end
   endtask

   task automatic test_armed_write();
      int leaks = 0;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      set_wr(4'd3, 12'd7, 12'd8, 12'd9, 12'd10, 8'h44, 1'b1);
      wr_valid = 1'b1;
      repeat (4) begin
         if (wr_ready !== 1'b0) leaks++;
         tick();
      end
      checks++;
      if (leaks !== 0) begin
         errors++; $display("FAIL armed_ready got %0d ready cycles want 0", leaks);
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if (wr_ready !== 1'b1 || box_xmin[36 +: 12] !== 12'd0 || update !== 10'h004) begin
         errors++;
         $display("FAIL armed_no_write got rdy=%b x3=%0d upd=%0h want rdy=1 x3=0 upd=004",
                  wr_ready, box_xmin[36 +: 12], update);
      end
      tick();
      wr_valid = 1'b0;
      do_commit();
      checks++;
      if (box_xmin[36 +: 12] !== 12'd7 || box_xmin[24 +: 12] !== 12'd10 || update !== 10'h00c) begin
         errors++;
         $display("FAIL late_write got x3=%0d x2=%0d upd=%0h want x3=7 x2=10 upd=00c",
                  box_xmin[36 +: 12], box_xmin[24 +: 12], update);
      end
   endtask

   task automatic test_bad_idx();
      logic [NBOX*CW-1:0] exp_x;
      exp_x = '0;
      exp_x[24 +: 12] = 12'd10;
      exp_x[36 +: 12] = 12'd7;
      do_write(4'd12, 12'hfff, 12'hfff, 12'hfff, 12'hfff, 8'hff, 1'b1);
      checks++;
      if (err_idx !== 1'b1) begin
         errors++; $display("FAIL err_idx_set got %b want 1", err_idx);
      end
      do_commit();
      checks++;
      if (box_xmin !== exp_x || update !== 10'h00c) begin
         errors++; $display("FAIL bad_idx_table got %0h upd=%0h want %0h upd=00c", box_xmin, update, exp_x);
      end
      checks++;
      if (err_idx !== 1'b1 || commit_done !== 1'b1) begin
         errors++; $display("FAIL err_idx_sticky got err=%b done=%b want 1 1", err_idx, commit_done);
      end
   endtask

   task automatic test_back_to_back();
      int done_seen = 0;
      do_write(4'd4, 12'd1, 12'd2, 12'd3, 12'd4, 8'h11, 1'b0);
      do_write(4'd4, 12'd99, 12'd100, 12'd101, 12'd102, 8'h55, 1'b1);
      set_wr(4'd5, 12'd55, 12'd56, 12'd57, 12'd58, 8'h66, 1'b1);
      wr_valid = 1'b1; commit_req = 1'b1; frame_start = 1'b1;
      tick();
      wr_valid = 1'b0; commit_req = 1'b0; frame_start = 1'b0;
      checks++;
      if (commit_pending !== 1'b1 || commit_done !== 1'b0 || box_xmin[48 +: 24] !== 24'd0) begin
         errors++;
         $display("FAIL arm_only got pend=%b done=%b x45=%0h want 1 0 0", commit_pending, commit_done,
                  box_xmin[48 +: 24]);
      end
      repeat (3) begin
         tick();
         if (commit_done === 1'b1) done_seen++;
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if (done_seen !== 0 || commit_done !== 1'b1) begin
         errors++; $display("FAIL next_frame_commit got early=%0d done=%b want 0 1", done_seen, commit_done);
      end
      checks++;
      if (box_xmin[48 +: 12] !== 12'd99 || box_xmin[60 +: 12] !== 12'd55 || thy[32 +: 8] !== 8'h55
          || update !== 10'h03c) begin
         errors++;
         $display("FAIL overwrite_same_cycle got x4=%0d x5=%0d t4=%0h upd=%0h want 99 55 55 03c",
                  box_xmin[48 +: 12], box_xmin[60 +: 12], thy[32 +: 8], update);
      end
   endtask

   task automatic test_timeout();
`ifdef BOXTBL_TIMEOUT_EN
      int n = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      do_write(4'd6, 12'd66, 12'd67, 12'd68, 12'd69, 8'h01, 1'b1);
      commit_req = 1'b1; tick(); commit_req = 1'b0;
      repeat (99) tick();
      checks++;
      if (commit_pending !== 1'b1 || commit_done !== 1'b0) begin
         errors++; $display("FAIL tmo_not_yet got pend=%b done=%b want 1 0", commit_pending, commit_done);
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++;
      if (commit_done !== 1'b1 || timeout !== 1'b0 || box_xmin[72 +: 12] !== 12'd66) begin
         errors++;
         $display("FAIL tmo_coincide got done=%b tmo=%b x6=%0d want 1 0 66", commit_done, timeout, box_xmin[72 +: 12]);
      end
      do_write(4'd7, 12'd77, 12'd78, 12'd79, 12'd80, 8'h02, 1'b1);
      commit_req = 1'b1; tick(); commit_req = 1'b0;
      while (commit_done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 100 || timeout !== 1'b1 || box_xmin[84 +: 12] !== 12'd77) begin
         errors++;
         $display("FAIL tmo_commit got cycles=%0d tmo=%b x7=%0d want 100 1 77", n, timeout, box_xmin[84 +: 12]);
      end
      rst = 1'b1; tick(); rst = 1'b0; tick();
      checks++;
      if (timeout !== 1'b0 || box_xmin !== '0 || err_idx !== 1'b0) begin
         errors++; $display("FAIL tmo_reset got tmo=%b err=%b want 0 0", timeout, err_idx);
      end
`else
      do_write(4'd6, 12'd66, 12'd67, 12'd68, 12'd69, 8'h01, 1'b1);
      commit_req = 1'b1; tick(); commit_req = 1'b0;
      repeat (150) tick();
      checks++;
      if (commit_pending !== 1'b1 || timeout !== 1'b0 || box_xmin[72 +: 12] !== 12'd0) begin
         errors++;
         $display("FAIL armed_wait got pend=%b tmo=%b x6=%0d want 1 0 0", commit_pending, timeout, box_xmin[72 +: 12]);
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++;
      if (commit_done !== 1'b1 || box_xmin[72 +: 12] !== 12'd66) begin
         errors++; $display("FAIL armed_wait_commit got done=%b x6=%0d want 1 66", commit_done, box_xmin[72 +: 12]);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_commit();
      test_armed_write();
      test_bad_idx();
      test_back_to_back();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
